vec_mem_sequencer: RTL and testbench
====================================

Name: vec_mem_sequencer

Overview:
- Initiator side of the 4-port data memory: converts one vector unit-stride or strided load/store command into per-cycle beats of up to 4 elements.
- Each beat is spread across memory ports 0..3.
- Sits between the vector execute stage and the data memory.
- Drives the 3-bit byte-lane enables, returns packed load data, and consumes packed store data.

Parameters:
- ADDR_WIDTH, 10, memory byte-address width; all address arithmetic wraps modulo 2^ADDR_WIDTH.
- VL_WIDTH, 8, width of the element count vl.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; captured on start.
- eew  in  2  element width: 00 = 8b, 01 = 16b, 10 = 32b, 11 = reserved (treated as 32b); captured on start.
- base_addr  in  ADDR_WIDTH  byte address of element 0.
- stride  in  ADDR_WIDTH  byte stride between elements, two's complement.
- vl  in  VL_WIDTH  number of elements; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at command completion.
- st_valid  in  1  store beat data valid.
- st_ready  out  1  store beat accepted this cycle.
- st_data  in  128  lane k data in bits [32k+31:32k], right-aligned.
- ld_valid  out  1  load beat valid; no backpressure.
- ld_data  out  128  lane k zero-extended element.
- ld_mask  out  4  active lanes of the ld_data beat.
- ld_last  out  1  qualifies the final load beat.
- mem_we0..mem_we3  out  3 each  per-port write enables.
- mem_re0..mem_re3  out  3 each  per-port read enables.
- mem_addr0..mem_addr3  out  ADDR_WIDTH each  per-port byte addresses.
- mem_wdata0..mem_wdata3  out  32 each  per-port write data.
- mem_rdata0..mem_rdata3  in  32 each  per-port read data; combinational read, same cycle as address.

Behaviour:
- **Reset.** Asserting rst_n low does all of the following:
  - all outputs go to 0 immediately;
  - FSM goes to IDLE;
  - counters, captured command and load pipeline register are cleared.
- Reset during RUN abandons the command. No further memory writes occur; beats already written stay written.
- **Enable encoding** (applies to both mem_we and mem_re of an active lane):
  - 8b -> 3'b001
  - 16b -> 3'b011
  - 32b -> 3'b111
  - Inactive lanes drive 3'b000 on both enables, and 0 on address and wdata.
- **FSM states:** IDLE, LOAD, STORE, FIN.
  - IDLE, start=1, vl!=0: capture the command; beat_addr = base_addr; remaining = vl; go to LOAD or STORE per is_store.
  - IDLE, start=1, vl=0: go to FIN. No memory activity.
  - start in any state other than IDLE is ignored.
- **Beat formation.**
  - n = min(4, remaining); lanes 0..n-1 are active.
  - Lane k address = beat_addr + k*stride, truncated to ADDR_WIDTH.
  - After each issued beat: beat_addr += 4*stride (truncated); remaining -= n.
- **LOAD state.**
  - Issues one beat every cycle with mem_re driven.
  - mem_rdata is registered at the clock edge.
  - ld_valid, ld_data, ld_mask assert the cycle after issue (latency 1).
  - ld_data lane k is masked to eew (upper bits 0); inactive lanes are 0.
  - After the final issue, go to FIN. ld_last accompanies the final ld_valid, coincident with the FIN cycle.
- **STORE state.**
  - st_ready = 1 throughout STORE.
  - A beat is issued, with mem_we and mem_wdata driven, only in cycles where st_valid=1. Otherwise all ports are idle and address/counters hold.
  - Store wdata lane k = st_data lane k masked to eew.
  - After the final accepted beat, go to FIN.
- **FIN state.** done=1 for exactly one cycle, busy=0, then IDLE. A start in the FIN cycle is ignored.
- **busy.** 1 in LOAD and STORE.
- **Address wrap-around** is silent modulo arithmetic; no error. Misalignment is the issuer's responsibility and is not checked.
- **Overlapping lanes** (e.g. stride=0 store): memory-side priority applies; this block does not arbitrate.

Test Plan:
- **32b unit-stride load:** base=0x010, stride=4, vl=6, memory bytes 0x10..0x27 = 0x00..0x17.
  - Beat 1: mem_re0..3=3'b111, addresses 0x010/0x014/0x018/0x01C; next cycle ld_data lane0=0x03020100, ld_mask=4'b1111.
  - Beat 2: ld_mask=4'b0011, ld_last=1; done pulses in the same cycle.
- **8b strided store with st_valid gap:** base=0x100, stride=3, vl=5, st_valid low for 2 cycles before the second beat.
  - Beat 1 uses mem_we=3'b001 on addresses 0x100/0x103/0x106/0x109.
  - During the gap, all mem_we=0 and addresses are held.
  - Beat 2 writes only port0 at 0x10C.
  - busy spans every cycle; done=1 once.
- **16b load with negative stride and wrap:** ADDR_WIDTH=10, base=0x002, stride=0x3FE (-2), vl=3.
  - Addresses 0x002/0x000/0x3FE; enables 3'b011; ld_data upper 16 bits of each lane = 0.
- **vl=0 start:** done pulses the cycle after start; no mem_re or mem_we activity; busy stays 0.
- **start while busy, and reset mid-store:**
  - A second start during LOAD is ignored.
  - Dropping rst_n during STORE beat 2 of 3 immediately zeroes mem_we, st_ready, busy and done.
  - Beat 3 never writes; after release the block sits in IDLE.

Source files
------------

// File: rtl/vec_mem_sequencer.sv
// Purpose: splits one vector load/store command into beats of up to 4 elements spread over memory ports 0..3.
// Latency: memory ports driven the issue cycle; load beats appear 1 cycle later on ld_*; done pulses one cycle after the last beat.
// Backpressure: stores issue only when st_valid is high; loads issue every cycle and ld_* cannot be stalled.
module vec_mem_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int VL_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [1:0]            eew,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [VL_WIDTH-1:0]   vl,
    output logic                  busy,
    output logic                  done,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [127:0]          st_data,
    output logic                  ld_valid,
    output logic [127:0]          ld_data,
    output logic [3:0]            ld_mask,
    output logic                  ld_last,
    output logic [2:0]            mem_we0,
    output logic [2:0]            mem_we1,
    output logic [2:0]            mem_we2,
    output logic [2:0]            mem_we3,
    output logic [2:0]            mem_re0,
    output logic [2:0]            mem_re1,
    output logic [2:0]            mem_re2,
    output logic [2:0]            mem_re3,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    output logic [ADDR_WIDTH-1:0] mem_addr3,
    output logic [31:0]           mem_wdata0,
    output logic [31:0]           mem_wdata1,
    output logic [31:0]           mem_wdata2,
    output logic [31:0]           mem_wdata3,
    input  logic [31:0]           mem_rdata0,
    input  logic [31:0]           mem_rdata1,
    input  logic [31:0]           mem_rdata2,
    input  logic [31:0]           mem_rdata3
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                state_q;
    logic                  is_store_q;
    logic [1:0]            eew_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] beat_addr_q;
    logic [VL_WIDTH-1:0]   remaining_q;
    logic                  ld_valid_q;
    logic [127:0]          ld_data_q;
    logic [3:0]            ld_mask_q;
    logic                  ld_last_q;

    logic [ADDR_WIDTH-1:0] beat_addr_d;
    logic [VL_WIDTH-1:0]   remaining_d;
    logic                  last_beat;
    logic                  rd_issue;
    logic                  wr_issue;
    logic [2:0]            en_code;
    logic [31:0]           elem_mask;
    logic [3:0]            lane_act;
    logic [127:0]          ld_beat;
    logic [ADDR_WIDTH-1:0] lane_addr [4];
    logic [31:0]           rdata_a   [4];
    logic [2:0]            we_a      [4];
    logic [2:0]            re_a      [4];
    logic [ADDR_WIDTH-1:0] addr_a    [4];
    logic [31:0]           wdata_a   [4];

    assign rdata_a[0] = mem_rdata0;
    assign rdata_a[1] = mem_rdata1;
    assign rdata_a[2] = mem_rdata2;
    assign rdata_a[3] = mem_rdata3;

    // Beat formation: active lanes, lane addresses, enables, masked data and next counters.
    always_comb begin
        rd_issue    = (state_q == LOAD);
        wr_issue    = (state_q == STORE) && st_valid;
        last_beat   = (remaining_q <= VL_WIDTH'(4));
        beat_addr_d = beat_addr_q + (stride_q << 2);
        remaining_d = last_beat ? '0 : (remaining_q - VL_WIDTH'(4));
        case (eew_q)
            2'b00:   begin en_code = 3'b001; elem_mask = 32'h0000_00FF; end
            2'b01:   begin en_code = 3'b011; elem_mask = 32'h0000_FFFF; end
            default: begin en_code = 3'b111; elem_mask = 32'hFFFF_FFFF; end
        endcase
        lane_addr[0] = beat_addr_q;
        for (int k = 1; k < 4; k++) begin
            lane_addr[k] = lane_addr[k-1] + stride_q;
        end
        ld_beat = '0;
        for (int k = 0; k < 4; k++) begin
            lane_act[k] = (remaining_q > VL_WIDTH'(k));
            re_a[k]     = (rd_issue && lane_act[k]) ? en_code : 3'b000;
            we_a[k]     = (wr_issue && lane_act[k]) ? en_code : 3'b000;
            addr_a[k]   = ((rd_issue || wr_issue) && lane_act[k]) ? lane_addr[k] : '0;
            wdata_a[k]  = (wr_issue && lane_act[k]) ? (st_data[32*k +: 32] & elem_mask) : 32'h0;
            if (lane_act[k]) begin
                ld_beat[32*k +: 32] = rdata_a[k] & elem_mask;
            end
        end
    end

    // Sequencer FSM with command capture, beat counters and the load return register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            eew_q       <= 2'b00;
            stride_q    <= '0;
            beat_addr_q <= '0;
            remaining_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_mask_q   <= '0;
            ld_last_q   <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            ld_mask_q  <= '0;
            ld_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_store_q  <= is_store;
                        eew_q       <= eew;
                        stride_q    <= stride;
                        beat_addr_q <= base_addr;
                        remaining_q <= vl;
                        if (vl == '0) begin
                            state_q <= FIN;
                        end else if (is_store) begin
                            state_q <= STORE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    ld_valid_q  <= 1'b1;
                    ld_data_q   <= ld_beat;
                    ld_mask_q   <= lane_act;
                    ld_last_q   <= last_beat;
                    beat_addr_q <= beat_addr_d;
                    remaining_q <= remaining_d;
                    if (last_beat) begin
                        state_q <= FIN;
                    end
                end
                STORE: begin
                    if (st_valid) begin
                        beat_addr_q <= beat_addr_d;
                        remaining_q <= remaining_d;
                        if (last_beat) begin
                            state_q <= FIN;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q == LOAD) || (state_q == STORE);
    assign done     = (state_q == FIN);
    assign st_ready = (state_q == STORE);
    assign ld_valid = ld_valid_q;
    assign ld_data  = ld_data_q;
    assign ld_mask  = ld_mask_q;
    assign ld_last  = ld_last_q;

    assign mem_we0    = we_a[0];
    assign mem_we1    = we_a[1];
    assign mem_we2    = we_a[2];
    assign mem_we3    = we_a[3];
    assign mem_re0    = re_a[0];
    assign mem_re1    = re_a[1];
    assign mem_re2    = re_a[2];
    assign mem_re3    = re_a[3];
    assign mem_addr0  = addr_a[0];
    assign mem_addr1  = addr_a[1];
    assign mem_addr2  = addr_a[2];
    assign mem_addr3  = addr_a[3];
    assign mem_wdata0 = wdata_a[0];
    assign mem_wdata1 = wdata_a[1];
    assign mem_wdata2 = wdata_a[2];
    assign mem_wdata3 = wdata_a[3];

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a byte-addressed behavioural memory on the four ports.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_store;
    logic [1:0]   eew;
    logic [9:0]   base_addr;
    logic [9:0]   stride;
    logic [7:0]   vl;
    logic         busy;
    logic         done;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_data;
    logic         ld_valid;
    logic [127:0] ld_data;
    logic [3:0]   ld_mask;
    logic         ld_last;
    logic [2:0]   mem_we0, mem_we1, mem_we2, mem_we3;
    logic [2:0]   mem_re0, mem_re1, mem_re2, mem_re3;
    logic [9:0]   mem_addr0, mem_addr1, mem_addr2, mem_addr3;
    logic [31:0]  mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3;
    logic [31:0]  mem_rdata0, mem_rdata1, mem_rdata2, mem_rdata3;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [1024];
    logic [9:0]  ad  [4];
    logic [31:0] rdat [4];

    always #5 clk = ~clk;

    vec_mem_sequencer #(.ADDR_WIDTH(10), .VL_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .eew(eew),
        .base_addr(base_addr), .stride(stride), .vl(vl), .busy(busy), .done(done),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_mask(ld_mask), .ld_last(ld_last),
        .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_we3(mem_we3),
        .mem_re0(mem_re0), .mem_re1(mem_re1), .mem_re2(mem_re2), .mem_re3(mem_re3),
        .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_addr3(mem_addr3),
        .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2), .mem_wdata3(mem_wdata3),
        .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2), .mem_rdata3(mem_rdata3)
    );

    assign ad[0] = mem_addr0;
    assign ad[1] = mem_addr1;
    assign ad[2] = mem_addr2;
    assign ad[3] = mem_addr3;

    // Combinational little-endian read, wrapping within the 1 KiB space.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdat[p] = {mem[ad[p] + 10'd3], mem[ad[p] + 10'd2], mem[ad[p] + 10'd1], mem[ad[p]]};
        end
    end

    assign mem_rdata0 = rdat[0];
    assign mem_rdata1 = rdat[1];
    assign mem_rdata2 = rdat[2];
    assign mem_rdata3 = rdat[3];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply this cycle's write enables to the memory (they are stable until the coming edge).
    task automatic commit_port(input logic [2:0] we, input logic [9:0] a, input logic [31:0] wd);
        if (we[0]) mem[a] = wd[7:0];
        if (we[1]) mem[a + 10'd1] = wd[15:8];
        if (we[2]) begin
            mem[a + 10'd2] = wd[23:16];
            mem[a + 10'd3] = wd[31:24];
        end
    endtask

    task automatic next();
        commit_port(mem_we0, mem_addr0, mem_wdata0);
        commit_port(mem_we1, mem_addr1, mem_wdata1);
        commit_port(mem_we2, mem_addr2, mem_wdata2);
        commit_port(mem_we3, mem_addr3, mem_wdata3);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; eew = 2'b00;
        base_addr = '0; stride = '0; vl = '0; st_valid = 1'b0; st_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 24; i++) mem[16 + i] = 8'(i);
        mem[10'h101] = 8'hEE;
        mem[10'h10D] = 8'hEE;
        mem[10'h000] = 8'hB0; mem[10'h001] = 8'hB1; mem[10'h002] = 8'hB2;
        mem[10'h003] = 8'hB3; mem[10'h004] = 8'hB4; mem[10'h005] = 8'hB5;
        mem[10'h3FE] = 8'hAE; mem[10'h3FF] = 8'hAF;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_st_ready", 128'(st_ready), 128'(0));
        chk("rst_ld_valid", 128'(ld_valid), 128'(0));
        chk("rst_ld_data", ld_data, 128'(0));
        chk("rst_re0", 128'(mem_re0), 128'(0));
        chk("rst_addr0", 128'(mem_addr0), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        next();

        // 32b unit-stride load, vl=6
        is_store = 1'b0; eew = 2'b10; base_addr = 10'h010; stride = 10'd4; vl = 8'd6; start = 1'b1;
        #1;
        chk("t1_busy_start_cycle", 128'(busy), 128'(0));
        next();
        start = 1'b0;
        #1;
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_b1_re", 128'({mem_re0, mem_re1, mem_re2, mem_re3}), 128'(12'o7777));
        chk("t1_b1_addr", 128'({mem_addr0, mem_addr1, mem_addr2, mem_addr3}),
            128'({10'h010, 10'h014, 10'h018, 10'h01C}));
        chk("t1_b1_ld_valid_early", 128'(ld_valid), 128'(0));
        next();
        start = 1'b1; base_addr = 10'h300; vl = 8'd2;
        #1;
        chk("t1_b1_ld_valid", 128'(ld_valid), 128'(1));
        chk("t1_b1_ld_data", ld_data, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100});
        chk("t1_b1_ld_mask", 128'(ld_mask), 128'(4'b1111));
        chk("t1_b1_ld_last", 128'(ld_last), 128'(0));
        chk("t1_b2_re", 128'({mem_re0, mem_re1, mem_re2, mem_re3}), 128'(12'o7700));
        chk("t1_b2_addr", 128'({mem_addr0, mem_addr1, mem_addr2, mem_addr3}),
            128'({10'h020, 10'h024, 10'h000, 10'h000}));
        next();
        #1;
        chk("t1_b2_ld_valid", 128'(ld_valid), 128'(1));
        chk("t1_b2_ld_data", ld_data, {32'h0, 32'h0, 32'h17161514, 32'h13121110});
        chk("t1_b2_ld_mask", 128'(ld_mask), 128'(4'b0011));
        chk("t1_b2_ld_last", 128'(ld_last), 128'(1));
        chk("t1_done", 128'(done), 128'(1));
        chk("t1_fin_busy", 128'(busy), 128'(0));
        chk("t1_fin_re0", 128'(mem_re0), 128'(0));
        next();
        start = 1'b0;
        #1;
        chk("t1_idle_busy", 128'(busy), 128'(0));
        chk("t1_idle_done", 128'(done), 128'(0));
        chk("t1_idle_ld_valid", 128'(ld_valid), 128'(0));
        next();

        // 8b strided store, vl=5, two-cycle st_valid gap
        is_store = 1'b1; eew = 2'b00; base_addr = 10'h100; stride = 10'd3; vl = 8'd5;
        start = 1'b1; st_valid = 1'b0;
        #1;
        next();
        start = 1'b0; st_valid = 1'b1;
        st_data = {32'hDEADBE44, 32'hDEADBE33, 32'hDEADBE22, 32'hDEADBE11};
        #1;
        chk("t2_b1_st_ready", 128'(st_ready), 128'(1));
        chk("t2_b1_we", 128'({mem_we0, mem_we1, mem_we2, mem_we3}), 128'(12'o1111));
        chk("t2_b1_addr", 128'({mem_addr0, mem_addr1, mem_addr2, mem_addr3}),
            128'({10'h100, 10'h103, 10'h106, 10'h109}));
        chk("t2_b1_wdata", 128'({mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3}),
            {32'h11, 32'h22, 32'h33, 32'h44});
        chk("t2_b1_re", 128'(mem_re0), 128'(0));
        next();
        st_valid = 1'b0;
        #1;
        chk("t2_gap1_we", 128'({mem_we0, mem_we1, mem_we2, mem_we3}), 128'(0));
        chk("t2_gap1_busy", 128'(busy), 128'(1));
        chk("t2_gap1_st_ready", 128'(st_ready), 128'(1));
        next();
        #1;
        chk("t2_gap2_we", 128'({mem_we0, mem_we1, mem_we2, mem_we3}), 128'(0));
        chk("t2_gap2_busy", 128'(busy), 128'(1));
        chk("t2_gap2_done", 128'(done), 128'(0));
        next();
        st_valid = 1'b1;
        st_data = {32'hCAFE0088, 32'hCAFE0077, 32'hCAFE0066, 32'h12345655};
        #1;
        chk("t2_b2_we", 128'({mem_we0, mem_we1, mem_we2, mem_we3}), 128'(12'o1000));
        chk("t2_b2_addr", 128'({mem_addr0, mem_addr1}), 128'({10'h10C, 10'h000}));
        chk("t2_b2_wdata", 128'({mem_wdata0, mem_wdata1}), 128'({32'h55, 32'h0}));
        chk("t2_b2_busy", 128'(busy), 128'(1));
        next();
        st_valid = 1'b0;
        #1;
        chk("t2_done", 128'(done), 128'(1));
        chk("t2_fin_busy", 128'(busy), 128'(0));
        chk("t2_fin_st_ready", 128'(st_ready), 128'(0));
        next();
        #1;
        chk("t2_idle_done", 128'(done), 128'(0));
        chk("t2_mem_100", 128'(mem[10'h100]), 128'(8'h11));
        chk("t2_mem_101", 128'(mem[10'h101]), 128'(8'hEE));
        chk("t2_mem_109", 128'(mem[10'h109]), 128'(8'h44));
        chk("t2_mem_10C", 128'(mem[10'h10C]), 128'(8'h55));
        chk("t2_mem_10D", 128'(mem[10'h10D]), 128'(8'hEE));
        next();

        // 16b load, stride -2, wrapping below address 0
        is_store = 1'b0; eew = 2'b01; base_addr = 10'h002; stride = 10'h3FE; vl = 8'd3; start = 1'b1;
        #1;
        next();
        start = 1'b0;
        #1;
        chk("t3_re", 128'({mem_re0, mem_re1, mem_re2, mem_re3}), 128'(12'o3330));
        chk("t3_addr", 128'({mem_addr0, mem_addr1, mem_addr2, mem_addr3}),
            128'({10'h002, 10'h000, 10'h3FE, 10'h000}));
        next();
        #1;
        chk("t3_ld_valid", 128'(ld_valid), 128'(1));
        chk("t3_ld_data", ld_data, {32'h0, 32'h0000AFAE, 32'h0000B1B0, 32'h0000B3B2});
        chk("t3_ld_mask", 128'(ld_mask), 128'(4'b0111));
        chk("t3_ld_last", 128'(ld_last), 128'(1));
        chk("t3_done", 128'(done), 128'(1));
        next();

        // vl=0 command
        is_store = 1'b0; eew = 2'b10; base_addr = 10'h040; stride = 10'd4; vl = 8'd0; start = 1'b1;
        #1;
        chk("t4_busy_start", 128'(busy), 128'(0));
        next();
        start = 1'b0;
        #1;
        chk("t4_done", 128'(done), 128'(1));
        chk("t4_busy", 128'(busy), 128'(0));
        chk("t4_re_we", 128'({mem_re0, mem_we0}), 128'(0));
        chk("t4_ld_valid", 128'(ld_valid), 128'(0));
        next();
        #1;
        chk("t4_done_clear", 128'(done), 128'(0));
        chk("t4_busy_after", 128'(busy), 128'(0));
        next();

        // 32b store of 3 beats, reset during beat 2
        is_store = 1'b1; eew = 2'b10; base_addr = 10'h200; stride = 10'd4; vl = 8'd12;
        start = 1'b1; st_valid = 1'b0;
        #1;
        next();
        start = 1'b0; st_valid = 1'b1; st_data = {4{32'hC0C1C2C3}};
        #1;
        chk("t5_b1_we0", 128'(mem_we0), 128'(3'b111));
        chk("t5_b1_addr0", 128'(mem_addr0), 128'(10'h200));
        next();
        st_data = {4{32'hD0D1D2D3}};
        #1;
        chk("t5_b2_we0", 128'(mem_we0), 128'(3'b111));
        chk("t5_b2_addr0", 128'(mem_addr0), 128'(10'h210));
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 128'({mem_we0, mem_we1, mem_we2, mem_we3}), 128'(0));
        chk("t5_rst_st_ready", 128'(st_ready), 128'(0));
        chk("t5_rst_busy", 128'(busy), 128'(0));
        chk("t5_rst_done", 128'(done), 128'(0));
        chk("t5_rst_addr0", 128'(mem_addr0), 128'(0));
        next();
        rst_n = 1'b1;
        #1;
        chk("t5_post_busy", 128'(busy), 128'(0));
        chk("t5_post_st_ready", 128'(st_ready), 128'(0));
        next();
        #1;
        chk("t5_idle_busy", 128'(busy), 128'(0));
        chk("t5_idle_we0", 128'(mem_we0), 128'(0));
        st_valid = 1'b0;
        chk("t5_mem_200", 128'(mem[10'h200]), 128'(8'hC3));
        chk("t5_mem_203", 128'(mem[10'h203]), 128'(8'hC0));
        chk("t5_mem_210", 128'(mem[10'h210]), 128'(8'h00));
        chk("t5_mem_220", 128'(mem[10'h220]), 128'(8'h00));
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
